ex3_to_bcd_packer: RTL
======================

Name: ex3_to_bcd_packer

Overview:
Sequential excess-3 to packed-BCD decoder, the receive-side counterpart of the BCD-to-excess-3 code converter.
- Accepts excess-3 digits serially, most significant digit first, over a valid/ready handshake.
- Decodes each digit to BCD and packs up to NDIG digits into one BCD word.
- Presents the word on a valid/ready output with a digit count and a sticky invalid-code flag.

Parameters:
NDIG, 4, number of BCD digits per output word (allowed range 1..8)
CW, $clog2(NDIG+1), width of the digit-count field (derived, not overridden)

Ports:
clk  input  1  single system clock; all state changes on its rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_digit/in_last are valid this cycle
in_ready  output  1  block can accept a digit this cycle
in_digit  input  4  excess-3 coded digit
in_last  input  1  this digit terminates the current word
out_valid  output  1  out_bcd/out_count/out_err are valid
out_ready  input  1  downstream accepts the word this cycle
out_bcd  output  4*NDIG  packed BCD word, right-aligned, least significant digit in [3:0]
out_count  output  CW  number of digits in the word (1..NDIG)
out_err  output  1  at least one digit of the word was an invalid excess-3 code

Behaviour:
- Reset (async assert, sync to clk on release):
  - State = ACC; out_valid = 0; out_bcd = 0; out_count = 0; out_err = 0; in_ready = 1.
- States:
  - ACC: collecting digits. in_ready = 1, out_valid = 0.
  - OUT: holding a completed word. in_ready = 0, out_valid = 1.
- Input accept: occurs when in_valid && in_ready.
- Digit decode:
  - Valid excess-3 codes are 4'b0011..4'b1100; bcd = in_digit - 3, using 4-bit arithmetic.
  - Codes 0000-0010 and 1101-1111 are invalid. The stored digit is 4'h0, and an internal sticky err bit is set.
- Packing:
  - On each accept: word <= {word[4*NDIG-5:0], bcd}; count <= count + 1.
  - Because the word shifts left, a word with fewer than NDIG digits is right-aligned with leading zero digits.
- Word completion: a word completes on an accept where in_last = 1, or where count + 1 == NDIG. The state moves ACC -> OUT on that edge.
- Latency: out_valid rises on the first clock edge after the final digit is accepted, i.e. one cycle after the final accept.
- Output hold:
  - In OUT, out_bcd, out_count and out_err hold stable until out_valid && out_ready.
  - On that edge the state moves to ACC, and word, count and err are cleared.
  - in_ready rises in the next cycle, so one bubble cycle occurs per word.
- in_last on digit NDIG: treated identically to an implicit completion, with a single word produced.
- in_valid while in OUT: not accepted. The upstream source holds the digit, per the handshake rule that data is stable while valid && !ready.
- out_ready while in ACC: ignored.
- Empty words: in_last cannot produce an empty word, because each accept adds a digit. out_count is never 0 while out_valid = 1.
- Reset mid-word or mid-OUT: the partial or held word is discarded with no output. out_valid drops immediately (asynchronous).
- out_err covers only the current word. It is cleared on the output handshake.

Decomposition:
- Package ex3_pkg:
  - Constants EX3_OFFSET = 4'd3, EX3_MIN = 4'd3, EX3_MAX = 4'd12.
  - State enum {ACC, OUT}.
- Sub-module ex3_digit_dec: purely combinational.
  - Input: 4-bit ex3 code.
  - Outputs: 4-bit bcd and a valid flag.
  - Reused by any later excess-3 datapath.
- The top level holds the FSM, shift register, counter and error bit.

Test Plan:
- Full word with NDIG=4, no backpressure: digits 0100, 0101, 0110, 0111 -> out_bcd = 16'h1234, out_count = 4, out_err = 0. out_valid rises 1 cycle after the 4th accept.
- Short word: digits 1100 then 0011 with in_last = 1 -> out_bcd = 16'h0090, out_count = 2, out_err = 0.
- Invalid code: digits 0011, 0000, 1111, 1100 -> out_bcd = 16'h0009, out_err = 1. The following valid word 0011x4 -> out_bcd = 16'h0000, out_err = 0.
- Backpressure: hold out_ready = 0 for 5 cycles after a word completes.
  - out_bcd, out_count and out_err stay constant; in_ready = 0.
  - A digit presented on in_valid is not consumed until 1 cycle after out_ready = 1.
- Exhaustive decode: all 16 codes, each sent as a single-digit word with in_last = 1.
  - Codes 3..12 -> digits 0..9 with err = 0.
  - The other six codes -> digit 0 with err = 1.
- Reset mid-word: accept 2 digits, assert rst for 1 cycle, then send 0100, 0101, 0110, 0111 -> single output 16'h1234 with count 4. No residue from the discarded digits.

Source files
------------

// File: rtl/ex3_pkg.sv
// Shared constants and state encoding for the excess-3 receive datapath.
package ex3_pkg;

  localparam logic [3:0] EX3_OFFSET = 4'd3;
  localparam logic [3:0] EX3_MIN    = 4'd3;
  localparam logic [3:0] EX3_MAX    = 4'd12;

  typedef enum logic {
    ACC,
    OUT
  } state_t;

endpackage

// File: rtl/ex3_digit_dec.sv
// Combinational excess-3 digit decoder; invalid codes map to digit 0 with valid low.
module ex3_digit_dec
  import ex3_pkg::*;
(
  input  logic [3:0] ex3,
  output logic [3:0] bcd,
  output logic       valid
);

  always_comb begin
    valid = (ex3 >= EX3_MIN) && (ex3 <= EX3_MAX);
    bcd   = valid ? (ex3 - EX3_OFFSET) : 4'h0;
  end

endmodule

// File: rtl/ex3_to_bcd_packer.sv
// Serial excess-3 to packed-BCD word packer with valid/ready on both sides.
module ex3_to_bcd_packer
  import ex3_pkg::*;
#(
  parameter  int NDIG = 4,
  localparam int CW   = $clog2(NDIG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_digit,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_bcd,
  output logic [CW-1:0]     out_count,
  output logic              out_err
);

  state_t            state, state_next;
  logic [4*NDIG-1:0] word, word_next;
  logic [CW-1:0]     count, count_inc;
  logic              err;
  logic [3:0]        dig_bcd;
  logic              dig_ok;
  logic              accept, complete, release_word;

  ex3_digit_dec u_dec (
    .ex3   (in_digit),
    .bcd   (dig_bcd),
    .valid (dig_ok)
  );

  assign in_ready     = (state == ACC);
  assign out_valid    = (state == OUT);
  assign accept       = in_valid && in_ready;
  assign count_inc    = count + CW'(1);
  assign complete     = accept && (in_last || (count_inc == CW'(NDIG)));
  assign release_word = out_valid && out_ready;

  // A one-digit word has nothing to shift up, so it needs its own slice-free path.
  generate
    if (NDIG == 1) begin : g_single
      assign word_next = dig_bcd;
    end else begin : g_multi
      assign word_next = {word[4*NDIG-5:0], dig_bcd};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACC:     if (complete)  state_next = OUT;
      OUT:     if (out_ready) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  // The accumulated word doubles as the held output; it is only cleared by the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (release_word) begin
      word  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (accept) begin
      word  <= word_next;
      count <= count_inc;
      err   <= err | ~dig_ok;
    end
  end

  assign out_bcd   = word;
  assign out_count = count;
  assign out_err   = err;

endmodule
